// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM configuration write scheduler: register map,
// ramp FSM state encoding and the register write-request record.
package pwm_cfg_pkg;

  localparam logic [6:0] REG_EN_OUT_LO = 7'h00;
  localparam logic [6:0] REG_EN_OUT_HI = 7'h01;
  localparam logic [6:0] REG_EN_PWM_LO = 7'h02;
  localparam logic [6:0] REG_EN_PWM_HI = 7'h03;
  localparam logic [6:0] REG_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_req_t;

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Free-running tick divider: counts 0..prescale while enabled, pulses tick on the
// terminal count and parks at zero whenever disabled.
module pwm_tick_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);

  logic [PRESC_W-1:0] count_q, count_d;

  always_comb begin
    tick    = en && (count_q == prescale);
    count_d = count_q + {{(PRESC_W-1){1'b0}}, 1'b1};
    if (!en || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// Arbitrates the PWM register-file write port between host (SPI) writes and a
// breathing-mode duty ramp engine; host writes always win.
module pwm_cfg_scheduler
  import pwm_cfg_pkg::*;
#(
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 8,
  parameter int                PRESC_W   = 16,
  parameter logic [ADDR_W-1:0] DUTY_ADDR = ADDR_W'(REG_DUTY)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               host_valid,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [DATA_W-1:0]  host_data,
  output logic               host_ready,
  input  logic               ramp_en,
  input  logic [DATA_W-1:0]  ramp_min,
  input  logic [DATA_W-1:0]  ramp_max,
  input  logic [DATA_W-1:0]  ramp_step,
  input  logic [PRESC_W-1:0] prescale,
  output logic               reg_wr_valid,
  output logic [ADDR_W-1:0]  reg_wr_addr,
  output logic [DATA_W-1:0]  reg_wr_data,
  input  logic               reg_wr_ready,
  output logic               ramp_overrun,
  output logic [1:0]         ramp_state
);

  ramp_state_t       state_q, state_d;
  logic [DATA_W-1:0] duty_q, duty_d;
  logic              pend_q, pend_d;
  logic              ovr_q, ovr_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              tick;
  logic              can_load, host_acc, ramp_load;
  logic [DATA_W:0]   up_nxt, dn_floor;

  pwm_tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (ramp_en),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    can_load  = !vld_q || reg_wr_ready;
    host_acc  = host_valid && can_load;
    ramp_load = pend_q && can_load && !host_valid;
    up_nxt    = {1'b0, duty_q} + {1'b0, ramp_step};
    dn_floor  = {1'b0, ramp_min} + {1'b0, ramp_step};

    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (host_acc) begin
      vld_d  = 1'b1;
      addr_d = host_addr;
      data_d = host_data;
    end else if (ramp_load) begin
      // A pending ramp write always carries the current duty value.
      vld_d  = 1'b1;
      addr_d = DUTY_ADDR;
      data_d = duty_q;
    end else if (reg_wr_ready) begin
      vld_d = 1'b0;
    end

    state_d = state_q;
    duty_d  = duty_q;
    pend_d  = pend_q && !ramp_load;
    ovr_d   = ovr_q;
    if (!ramp_en) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = UP;
      duty_d  = ramp_min;
      pend_d  = 1'b1;
    end else if (host_acc && (host_addr == DUTY_ADDR)) begin
      duty_d = host_data;
      pend_d = 1'b0;
    end else if (tick) begin
      pend_d = 1'b1;
      if (pend_q && !ramp_load) begin
        ovr_d = 1'b1;
      end
      if (state_q == UP) begin
        if (up_nxt >= {1'b0, ramp_max}) begin
          duty_d  = ramp_max;
          state_d = DOWN;
        end else begin
          duty_d = up_nxt[DATA_W-1:0];
        end
      end else begin
        // Turn around as soon as the next step would reach or pass the floor.
        if ({1'b0, duty_q} <= dn_floor) begin
          duty_d  = ramp_min;
          state_d = UP;
        end else begin
          duty_d = duty_q - ramp_step;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign host_ready   = can_load;
  assign reg_wr_valid = vld_q;
  assign reg_wr_addr  = addr_q;
  assign reg_wr_data  = data_q;
  assign ramp_overrun = ovr_q;
  assign ramp_state   = state_q;

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Directed and randomized checks of pwm_cfg_scheduler against a cycle-level
// integer reference model of the arbitration and breathing ramp.
module tb_pwm_cfg_scheduler;
  import pwm_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_valid;
  logic [6:0]  host_addr;
  logic [7:0]  host_data;
  logic        host_ready;
  logic        ramp_en;
  logic [7:0]  ramp_min, ramp_max, ramp_step;
  logic [15:0] prescale;
  logic        reg_wr_valid;
  logic [6:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        reg_wr_ready;
  logic        ramp_overrun;
  logic [1:0]  ramp_state;

  always #5 clk = ~clk;

  pwm_cfg_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .host_valid   (host_valid),
    .host_addr    (host_addr),
    .host_data    (host_data),
    .host_ready   (host_ready),
    .ramp_en      (ramp_en),
    .ramp_min     (ramp_min),
    .ramp_max     (ramp_max),
    .ramp_step    (ramp_step),
    .prescale     (prescale),
    .reg_wr_valid (reg_wr_valid),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_ready (reg_wr_ready),
    .ramp_overrun (ramp_overrun),
    .ramp_state   (ramp_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model (plain integers)
  int m_vld, m_pend, m_pval, m_duty, m_dir, m_ovr, en_cycles, cyc, last_dir;
  wr_req_t m_slot;
  int issued[$];
  int issue_cyc[$];
  int dirs[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_slot = '0; m_pend = 0; m_pval = 0; m_duty = 0;
    m_dir = 0; m_ovr = 0; en_cycles = 0;
  endtask

  task automatic step();
    bit can_load, hacc, rload, tick;
    int mn, mx, st, ps;
    #2;
    mn = int'(ramp_min); mx = int'(ramp_max); st = int'(ramp_step); ps = int'(prescale);
    can_load = (m_vld == 0) || reg_wr_ready;
    check("host_ready", host_ready, can_load);
    if (reg_wr_valid && reg_wr_ready && reg_wr_addr == 7'h04) begin
      issued.push_back(int'(reg_wr_data));
      issue_cyc.push_back(cyc);
    end
    hacc  = host_valid && can_load;
    rload = (m_pend != 0) && can_load && !host_valid;
    tick  = ramp_en && ((en_cycles % (ps + 1)) == ps);
    if (hacc) begin
      m_vld = 1; m_slot = '{addr: host_addr, data: host_data};
    end else if (rload) begin
      m_vld = 1; m_slot = '{addr: 7'h04, data: 8'(m_pval)};
    end else if (reg_wr_ready) begin
      m_vld = 0;
    end
    if (!ramp_en) begin
      m_dir = 0; m_pend = 0;
    end else if (m_dir == 0) begin
      m_dir = 1; m_duty = mn; m_pend = 1; m_pval = mn;
    end else if (hacc && host_addr == 7'h04) begin
      m_duty = int'(host_data); m_pend = 0;
    end else begin
      if (rload) m_pend = 0;
      if (tick) begin
        if (m_pend != 0) m_ovr = 1;
        if (m_dir == 1) begin
          if (m_duty + st >= mx) begin m_duty = mx; m_dir = 2; end
          else m_duty = m_duty + st;
        end else begin
          if (m_duty - st <= mn) begin m_duty = mn; m_dir = 1; end
          else m_duty = m_duty - st;
        end
        m_pend = 1; m_pval = m_duty;
      end
    end
    en_cycles = ramp_en ? en_cycles + 1 : 0;
    if (rst) model_reset();
    @(posedge clk);
    #1;
    cyc++;
    check("wr_valid", reg_wr_valid, m_vld);
    check("wr_addr", reg_wr_addr, m_slot.addr);
    check("wr_data", reg_wr_data, m_slot.data);
    check("ramp_state", ramp_state, m_dir);
    check("overrun", ramp_overrun, m_ovr);
    if (int'(ramp_state) != last_dir) begin
      if (ramp_state != 2'd0) dirs.push_back(int'(ramp_state));
      last_dir = int'(ramp_state);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ramp[8];
    int found;
    logic [7:0] held;
    exp_ramp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h30, 8'h20, 8'h10, 8'h20};
    cyc = 0; last_dir = 0;
    rst = 1; host_valid = 0; host_addr = 0; host_data = 0; ramp_en = 0;
    ramp_min = 0; ramp_max = 0; ramp_step = 0; prescale = 0; reg_wr_ready = 1;
    model_reset();
    @(posedge clk); #1;
    step();
    rst = 0;
    step();
    check("rst_valid", reg_wr_valid, 1'b0);
    check("rst_state", ramp_state, 2'd0);
    check("rst_ovr", ramp_overrun, 1'b0);
    check("rst_data", reg_wr_data, 8'h00);

    // Single host write
    host_valid = 1; host_addr = 7'h02; host_data = 8'hFF;
    #2 check("hw_ready", host_ready, 1'b1);
    step();
    check("hw_valid", reg_wr_valid, 1'b1);
    check("hw_addr", reg_wr_addr, 7'h02);
    check("hw_data", reg_wr_data, 8'hFF);
    host_valid = 0;
    step();

    // Breathing ramp sequence and tick spacing
    issued.delete(); issue_cyc.delete(); dirs.delete();
    ramp_min = 8'h10; ramp_max = 8'h40; ramp_step = 8'h10; prescale = 16'd3;
    ramp_en = 1;
    repeat (32) step();
    check("ramp_count", issued.size() >= 8, 1'b1);
    for (int k = 0; k < 8; k++)
      check($sformatf("ramp_val%0d", k), (k < issued.size()) ? issued[k] : -1, exp_ramp[k]);
    for (int k = 2; k < 8; k++)
      check($sformatf("ramp_gap%0d", k),
            (k < issue_cyc.size()) ? issue_cyc[k] - issue_cyc[k-1] : -1, 4);
    check("dir0", (dirs.size() > 0) ? dirs[0] : -1, 1);
    check("dir1", (dirs.size() > 1) ? dirs[1] : -1, 2);
    check("dir2", (dirs.size() > 2) ? dirs[2] : -1, 1);

    // Host write collides with a pending ramp write
    for (int i = 0; i < 10 && m_pend == 0; i++) step();
    check("pend_found", m_pend, 1);
    host_valid = 1; host_addr = 7'h00; host_data = 8'hAA;
    step();
    check("coll_host_addr", reg_wr_addr, 7'h00);
    check("coll_host_data", reg_wr_data, 8'hAA);
    host_valid = 0;
    step();
    check("coll_ramp_valid", reg_wr_valid, 1'b1);
    check("coll_ramp_addr", reg_wr_addr, 7'h04);

    // Backpressure with a tick every cycle
    ramp_en = 0;
    step();
    prescale = 16'd0; ramp_en = 1; reg_wr_ready = 0;
    step(); step();
    held = reg_wr_data;
    repeat (18) step();
    check("bp_valid", reg_wr_valid, 1'b1);
    check("bp_hold", reg_wr_data, held);
    check("bp_ovr", ramp_overrun, 1'b1);
    reg_wr_ready = 1;
    repeat (3) step();
    check("bp_ovr_sticky", ramp_overrun, 1'b1);

    // Host duty override in UP, next ramp write clamps at max
    ramp_en = 0;
    step();
    prescale = 16'd3; ramp_en = 1;
    step();
    host_valid = 1; host_addr = 7'h04; host_data = 8'h35;
    step();
    check("ovr_fwd_addr", reg_wr_addr, 7'h04);
    check("ovr_fwd_data", reg_wr_data, 8'h35);
    host_valid = 0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step();
      if (reg_wr_valid && reg_wr_addr == 7'h04) found = 1;
    end
    check("clamp_found", found, 1);
    check("clamp_data", reg_wr_data, 8'h40);
    check("clamp_state", ramp_state, 2'd2);

    // Reset while a write is in flight in DOWN
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (ramp_state == 2'd2 && reg_wr_valid) found = 1;
      else step();
    end
    check("rst_setup", found, 1);
    rst = 1;
    step();
    check("midrst_valid", reg_wr_valid, 1'b0);
    check("midrst_state", ramp_state, 2'd0);
    check("midrst_ovr", ramp_overrun, 1'b0);
    rst = 0;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        if (!ramp_en) begin
          ramp_min  = 8'($urandom);
          ramp_max  = 8'($urandom);
          ramp_step = 8'($urandom_range(0, 80));
          prescale  = 16'($urandom_range(0, 4));
        end
        ramp_en = !ramp_en;
      end
      host_valid   = ($urandom_range(0, 3) == 0);
      host_addr    = 7'($urandom_range(0, 4));
      host_data    = 8'($urandom);
      reg_wr_ready = ($urandom_range(0, 3) != 0);
      rst          = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
